// File: rtl/program_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | program_loader_pkg                                                    |
// | Shared word typedefs, default ack bytes and loader state encodings.   |
// | Optional feature macro: LOADER_CHECKSUM_EN                            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package program_loader_pkg;

  typedef logic [31:0] w32;
  typedef logic [31:0] r32;

  localparam logic [7:0] C_ACK_OK = 8'hAA;
  localparam logic [7:0] C_ACK_NG = 8'h55;

  typedef logic [2:0] state_t;
  localparam state_t C_ST_HDR  = 3'd0;
  localparam state_t C_ST_DATA = 3'd1;
  localparam state_t C_ST_ACK  = 3'd2;
  localparam state_t C_ST_RUN  = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t C_ST_CSUM = 3'd4;
`endif

  // True when word index k fits in an aw-bit address (no wrap allowed).
  function automatic logic word_in_range(input w32 k, input int aw);
    return (aw >= 32) || ((k >> aw) == 32'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/program_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | program_loader_if                                                     |
// | Byte receive, instruction-memory write, ack transmit and core control.|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface program_loader_if #(
  parameter int ADDR_W = 15
);
  import program_loader_pkg::*;

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  w32                wr_data;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              core_reset;
  logic              loading;

  modport slave (
    input  rx_valid, rx_data, tx_ready,
    output wr_en, wr_addr, wr_data, tx_valid, tx_data, core_reset, loading
  );

  modport master (
    output rx_valid, rx_data, tx_ready,
    input  wr_en, wr_addr, wr_data, tx_valid, tx_data, core_reset, loading
  );

endinterface
`default_nettype wire

// File: rtl/program_loader_byte_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_assembler                                                        |
// | Packs 4 bytes little-endian into a word; word_done marks the 4th byte.|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module byte_assembler
  import program_loader_pkg::*;
(
  input  wire logic       clock,
  input  wire logic       reset,
  input  wire logic       clear,
  input  wire logic       byte_valid,
  input  wire logic [7:0] byte_data,
  output w32              word,
  output logic            word_done
);

  // Only the three earlier bytes need storing; the 4th is the live input.
  logic [23:0] r_shift;
  logic [1:0]  r_byte_idx;

  assign word      = {byte_data, r_shift};
  assign word_done = byte_valid && (r_byte_idx == 2'd3);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_shift    <= 24'd0;
      r_byte_idx <= 2'd0;
    end else if (byte_valid) begin
      r_shift    <= {byte_data, r_shift[23:8]};
      r_byte_idx <= r_byte_idx + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | program_loader                                                        |
// | Loads a length-prefixed word stream into instruction memory, acks it, |
// | then releases the core. Optional macro: LOADER_CHECKSUM_EN            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDR_W = 15,
  parameter logic [7:0] ACK_OK = C_ACK_OK,
  parameter logic [7:0] ACK_NG = C_ACK_NG
) (
  input  wire logic         clock,
  input  wire logic         reset,
  program_loader_if.slave   bus
);

  state_t            r_state;
  state_t            w_next;
  r32                r_count;
  r32                r_word_cnt;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  r32                r_wr_data;
  logic              r_tx_valid;
  logic [7:0]        r_tx_data;
  logic              r_core_reset;
  w32                w_word;
  logic              w_word_done;
  logic              w_rx_take;
  logic              w_last;
  logic              w_ack_ok;
  logic              w_handshake;

  assign w_rx_take   = bus.rx_valid &&
                       (r_state != C_ST_ACK) && (r_state != C_ST_RUN);
  assign w_last      = (r_word_cnt + 32'd1) == r_count;
  assign w_handshake = r_tx_valid && bus.tx_ready;

`ifdef LOADER_CHECKSUM_EN
  r32   r_sum;
  logic r_ack_ok;
  // ACK is only entered from CSUM, so the live word is the trailing checksum.
  assign w_ack_ok = (w_word == r_sum);
`else
  assign w_ack_ok = 1'b1;
`endif

  byte_assembler u_byte_assembler (
    .clock      (clock),
    .reset      (reset),
    .clear      (w_next != r_state),
    .byte_valid (w_rx_take),
    .byte_data  (bus.rx_data),
    .word       (w_word),
    .word_done  (w_word_done)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      C_ST_HDR: begin
        if (w_word_done) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = (w_word == 32'd0) ? C_ST_CSUM : C_ST_DATA;
`else
          w_next = (w_word == 32'd0) ? C_ST_ACK : C_ST_DATA;
`endif
        end
      end
      C_ST_DATA: begin
        if (w_word_done && w_last) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = C_ST_CSUM;
`else
          w_next = C_ST_ACK;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      C_ST_CSUM: if (w_word_done) w_next = C_ST_ACK;
      C_ST_ACK:  if (w_handshake) w_next = r_ack_ok ? C_ST_RUN : C_ST_HDR;
`else
      C_ST_ACK:  if (w_handshake) w_next = C_ST_RUN;
`endif
      C_ST_RUN:  w_next = C_ST_RUN;
      default:   w_next = C_ST_HDR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= C_ST_HDR;
      r_count      <= 32'd0;
      r_word_cnt   <= 32'd0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= 32'd0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'd0;
      r_core_reset <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      r_sum        <= 32'd0;
      r_ack_ok     <= 1'b0;
`endif
    end else begin
      r_state      <= w_next;
      r_wr_en      <= 1'b0;
      r_core_reset <= (w_next != C_ST_RUN);
      case (r_state)
        C_ST_HDR: begin
          r_word_cnt <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
          r_sum      <= 32'd0;
`endif
          if (w_word_done) r_count <= w_word;
        end
        C_ST_DATA: begin
          if (w_word_done) begin
            r_word_cnt <= r_word_cnt + 32'd1;
`ifdef LOADER_CHECKSUM_EN
            r_sum      <= r_sum + w_word;
`endif
            if (word_in_range(r_word_cnt, ADDR_W)) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_word_cnt[ADDR_W-1:0];
              r_wr_data <= w_word;
            end
          end
        end
        C_ST_ACK: if (w_handshake) r_tx_valid <= 1'b0;
        default: ;
      endcase
      if ((w_next == C_ST_ACK) && (r_state != C_ST_ACK)) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_ack_ok ? ACK_OK : ACK_NG;
`ifdef LOADER_CHECKSUM_EN
        r_ack_ok   <= w_ack_ok;
`endif
      end
    end
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.tx_valid   = r_tx_valid;
  assign bus.tx_data    = r_tx_data;
  assign bus.core_reset = r_core_reset;
  assign bus.loading    = (r_state == C_ST_HDR) || (r_state == C_ST_DATA);

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_program_loader                                                     |
// | Directed checks of program_loader (default and 2-bit-address builds). |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_program_loader;
    import program_loader_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] log_a_addr[$];
    logic [31:0] log_a_data[$];
    logic [31:0] log_b_addr[$];
    logic [31:0] log_b_data[$];

    always #5 clock = ~clock;

    program_loader_if #(.ADDR_W(15)) bus_a ();
    program_loader_if #(.ADDR_W(2))  bus_b ();

    program_loader #(.ADDR_W(15)) dut_a (.clock(clock), .reset(reset), .bus(bus_a.slave));
    program_loader #(.ADDR_W(2))  dut_b (.clock(clock), .reset(reset), .bus(bus_b.slave));

    always @(posedge clock) begin
        if (bus_a.wr_en === 1'b1) begin
            log_a_addr.push_back(32'(bus_a.wr_addr));
            log_a_data.push_back(bus_a.wr_data);
        end
        if (bus_b.wr_en === 1'b1) begin
            log_b_addr.push_back(32'(bus_b.wr_addr));
            log_b_data.push_back(bus_b.wr_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxxxxxx;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b);
        if (sel == 0) begin
            bus_a.rx_valid = 1'b1;
            bus_a.rx_data  = b;
        end else begin
            bus_b.rx_valid = 1'b1;
            bus_b.rx_data  = b;
        end
        step();
        bus_a.rx_valid = 1'b0;
        bus_b.rx_valid = 1'b0;
    endtask

    task automatic send_word(input int sel, input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(sel, w[8*i +: 8]);
    endtask

    task automatic clear_logs();
        log_a_addr.delete();
        log_a_data.delete();
        log_b_addr.delete();
        log_b_data.delete();
    endtask

    initial begin
        reset          = 1'b1;
        bus_a.rx_valid = 1'b0;
        bus_a.rx_data  = 8'd0;
        bus_a.tx_ready = 1'b0;
        bus_b.rx_valid = 1'b0;
        bus_b.rx_data  = 8'd0;
        bus_b.tx_ready = 1'b0;
        step();
        step();

        check("rst_wr_en", 64'(bus_a.wr_en), 64'(1'b0));
        check("rst_tx_valid", 64'(bus_a.tx_valid), 64'(1'b0));
        check("rst_tx_data", 64'(bus_a.tx_data), 64'(8'h00));
        check("rst_core_reset", 64'(bus_a.core_reset), 64'(1'b1));
        check("rst_loading", 64'(bus_a.loading), 64'(1'b1));
        reset = 1'b0;

        send_word(0, 32'd2);
        send_word(0, 32'h12345678);
        send_word(0, 32'hDEADBEEF);
`ifdef LOADER_CHECKSUM_EN
        send_word(0, 32'hF0E21567);
`endif
        step();
        check("t1_nwrites", 64'(log_a_addr.size()), 64'd2);
        check("t1_addr0", 64'(qget(log_a_addr, 0)), 64'd0);
        check("t1_data0", 64'(qget(log_a_data, 0)), 64'h12345678);
        check("t1_addr1", 64'(qget(log_a_addr, 1)), 64'd1);
        check("t1_data1", 64'(qget(log_a_data, 1)), 64'hDEADBEEF);
        check("t1_tx_valid", 64'(bus_a.tx_valid), 64'(1'b1));
        check("t1_tx_data", 64'(bus_a.tx_data), 64'(8'hAA));
        check("t1_loading", 64'(bus_a.loading), 64'(1'b0));

        for (int i = 0; i < 10; i++) begin
            step();
            check("t1_ack_hold", 64'({bus_a.tx_valid, bus_a.tx_data, bus_a.core_reset}),
                  64'({1'b1, 8'hAA, 1'b1}));
        end
        bus_a.tx_ready = 1'b1;
        step();
        bus_a.tx_ready = 1'b0;
        check("t1_run_core_reset", 64'(bus_a.core_reset), 64'(1'b0));
        check("t1_run_tx_valid", 64'(bus_a.tx_valid), 64'(1'b0));
        send_word(0, 32'hCAFEF00D);
        step();
        check("t1_run_no_write", 64'(log_a_addr.size()), 64'd2);
        check("t1_run_stays", 64'(bus_a.core_reset), 64'(1'b0));

        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_logs();
        send_word(0, 32'd0);
`ifdef LOADER_CHECKSUM_EN
        send_word(0, 32'd0);
`endif
        check("t2_tx_valid", 64'(bus_a.tx_valid), 64'(1'b1));
        check("t2_tx_data", 64'(bus_a.tx_data), 64'(8'hAA));
        check("t2_core_reset_pre", 64'(bus_a.core_reset), 64'(1'b1));
        bus_a.tx_ready = 1'b1;
        step();
        bus_a.tx_ready = 1'b0;
        check("t2_core_reset_post", 64'(bus_a.core_reset), 64'(1'b0));
        check("t2_no_write", 64'(log_a_addr.size()), 64'd0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_logs();
        send_word(0, 32'd1);
        send_byte(0, 8'h11);
        send_byte(0, 8'h22);
        reset = 1'b1;
        step();
        check("t3_wr_en_in_reset", 64'(bus_a.wr_en), 64'(1'b0));
        reset = 1'b0;
        step();
        check("t3_wr_en_after", 64'(bus_a.wr_en), 64'(1'b0));
        check("t3_loading", 64'(bus_a.loading), 64'(1'b1));
        send_word(0, 32'd1);
        send_word(0, 32'h11223344);
`ifdef LOADER_CHECKSUM_EN
        send_word(0, 32'h11223344);
`endif
        step();
        check("t3_nwrites", 64'(log_a_addr.size()), 64'd1);
        check("t3_addr0", 64'(qget(log_a_addr, 0)), 64'd0);
        check("t3_data0", 64'(qget(log_a_data, 0)), 64'h11223344);

        send_word(1, 32'd5);
        for (int k = 0; k < 5; k++) send_word(1, 32'h01010101 * 32'(k + 1));
`ifdef LOADER_CHECKSUM_EN
        send_word(1, 32'h0F0F0F0F);
`endif
        step();
        check("t4_nwrites", 64'(log_b_addr.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check("t4_addr", 64'(qget(log_b_addr, k)), 64'(k));
            check("t4_data", 64'(qget(log_b_data, k)), 64'(32'h01010101 * 32'(k + 1)));
        end
        check("t4_tx_valid", 64'(bus_b.tx_valid), 64'(1'b1));
        check("t4_tx_data", 64'(bus_b.tx_data), 64'(8'hAA));

`ifdef LOADER_CHECKSUM_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        send_word(0, 32'd1);
        send_word(0, 32'd1);
        send_word(0, 32'd2);
        check("t5_ng_tx_data", 64'(bus_a.tx_data), 64'(8'h55));
        check("t5_ng_tx_valid", 64'(bus_a.tx_valid), 64'(1'b1));
        bus_a.tx_ready = 1'b1;
        step();
        bus_a.tx_ready = 1'b0;
        check("t5_ng_core_reset", 64'(bus_a.core_reset), 64'(1'b1));
        check("t5_ng_loading", 64'(bus_a.loading), 64'(1'b1));
        send_word(0, 32'd1);
        send_word(0, 32'd1);
        send_word(0, 32'd1);
        check("t5_ok_tx_data", 64'(bus_a.tx_data), 64'(8'hAA));
        bus_a.tx_ready = 1'b1;
        step();
        bus_a.tx_ready = 1'b0;
        check("t5_ok_core_reset", 64'(bus_a.core_reset), 64'(1'b0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
- REQ-001 Parameter ADDR_W, default 15, instruction-memory word-address width.
- REQ-002 Parameter ACK_OK, default 8'hAA, reply byte on successful load.
- REQ-003 Parameter ACK_NG, default 8'h55, reply byte on checksum failure (used only with LOADER_CHECKSUM_EN).
- REQ-004 clock  in  1  single clock; every register SHALL update on its rising edge.
- REQ-005 reset  in  1  synchronous, active-high reset.
- REQ-006 rx_valid  in  1  one-cycle strobe: rx_data holds a received byte (no backpressure).
- REQ-007 rx_data  in  8  received byte.
- REQ-008 wr_en  out  1  instruction-memory write strobe.
- REQ-009 wr_addr  out  ADDR_W  instruction-memory word address.
- REQ-010 wr_data  out  32  instruction word.
- REQ-011 tx_valid  out  1  ack byte offered to the transmitter.
- REQ-012 tx_data  out  8  ack byte.
- REQ-013 tx_ready  in  1  transmitter accepts tx_data while tx_valid is high.
- REQ-014 core_reset  out  1  holds the core (fetch PC at 0, pipeline flushed) in reset.
- REQ-015 loading  out  1  high in HDR and DATA.

Function
- REQ-016 States SHALL be HDR, DATA, (CSUM), ACK and RUN.
- REQ-017 HDR SHALL assemble 4 bytes little-endian into word count N, then go to DATA (or ACK if N==0 and checksum is disabled, or CSUM if N==0 and checksum is enabled).
- REQ-018 DATA SHALL assemble each group of 4 bytes little-endian into one word (first byte = bits 7:0).
- REQ-019 The write SHALL occur the cycle after the 4th byte is accepted: wr_en high for exactly 1 cycle, wr_addr = word index k (0-based), wr_data = assembled word.
- REQ-020 Words with index k >= 2**ADDR_W SHALL be consumed without being written (no address wrap).
- REQ-021 After word N-1 is consumed, DATA SHALL move to ACK, or to CSUM with the checksum enabled.
- REQ-022 ACK SHALL hold tx_valid=1 with tx_data=ACK_OK until the cycle tx_valid&tx_ready is seen, then move to RUN.
- REQ-023 RUN SHALL drive core_reset=0 and ignore rx_valid; RUN SHALL be left only by reset.
- REQ-024 core_reset SHALL be 1 in every state except RUN, and SHALL fall in the cycle after the ack handshake.
- REQ-025 The byte counter (2 bits) SHALL wrap 3->0 on each completed word; the word counter SHALL be 32 bits wide, so N up to 2**32-1 is counted exactly.
- REQ-026 rx_valid in ACK SHALL be ignored.

Reset
- REQ-027 Reset SHALL set state=HDR, all counters=0, wr_en=0, tx_valid=0, tx_data=0, core_reset=1 and loading=1.
- REQ-028 Reset asserted mid-load SHALL discard the partial word and the count, with no write in the following cycle.

Configuration
- REQ-029 With `LOADER_CHECKSUM_EN defined: a 32-bit wrapping sum of all N data words (including discarded ones) SHALL accumulate, and a trailing 4-byte little-endian word SHALL be received in CSUM.
- REQ-030 With `LOADER_CHECKSUM_EN defined: on a match, ACK SHALL send ACK_OK; on a mismatch, ACK SHALL send ACK_NG and then return to HDR with core_reset held at 1 instead of entering RUN.
- REQ-031 Without `LOADER_CHECKSUM_EN: there SHALL be no CSUM state, no accumulator and no trailing word, and the ack SHALL always be ACK_OK.

Structure
- REQ-032 The loader state enum and the default ACK_OK/ACK_NG constants SHALL live in the shared typedefs header, and w32/r32 SHALL be used for 32-bit signals.
- REQ-033 A sub-module byte_assembler SHALL be used (4-byte little-endian shift register, byte index and word_done strobe), instantiated once and cleared on reset and on each state entry.

Verification
- REQ-034 Bytes 02 00 00 00 | 78 56 34 12 | EF BE AD DE -> wr_en pulses twice: (addr 0, 32'h12345678), then (addr 1, 32'hDEADBEEF); then tx_data=AA.
- REQ-035 Header 00 00 00 00 -> no wr_en; ack AA; core_reset falls the cycle after handshake (checksum disabled).
- REQ-036 tx_ready held low 10 cycles in ACK -> tx_valid and tx_data stable for the 10 cycles, core_reset stays 1; tx_ready=1 -> RUN next cycle; later rx bytes cause no writes.
- REQ-037 reset pulsed after 2 data bytes of word 0, then a full valid stream is sent -> first write is addr 0 with the new word only.
- REQ-038 ADDR_W=2, N=5 -> writes only to addr 0..3; 5th word consumed but not written; ack AA.
- REQ-039 LOADER_CHECKSUM_EN, N=1, word 00000001, checksum 00000002 -> ack 55, core_reset stays 1, state HDR; resending with checksum 00000001 -> ack AA, then RUN.
